// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed little-endian word stream,
// writes it into instruction memory and answers with an ACK/NAK checksum verdict.
module prog_loader #(
  parameter int         ADDR_WIDTH     = 13,
  parameter int         TIMEOUT_CYCLES = 23040,
  parameter logic [7:0] ACK            = 8'h06,
  parameter logic [7:0] NAK            = 8'h15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_mode,
  input  logic [7:0]            rx_data,
  input  logic                  rx_full,
  output logic                  rd,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_rst,
  output logic                  prog_done
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, SEND, FIN
  } state_t;

  state_t          state, state_nxt;
  logic            rd_q;
  logic            armed;
  logic            consuming;
  logic            timeout;
  logic            in_range;
  logic            last_word;
  logic [7:0]      sum;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [7:0]      data_lo;
  logic [16:0]     word_cnt;
  logic [TO_W-1:0] to_cnt;

  // Word counter is one bit wider than the length so it never wraps; words
  // beyond the memory are consumed and summed but not written.
  assign in_range  = (word_cnt >> ADDR_WIDTH) == 17'd0;
  assign last_word = (word_cnt + 17'd1) == {1'b0, len};
  assign prog_done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    wr        = 1'b0;
    timeout   = 1'b0;
    consuming = (state == LEN_LO) || (state == LEN_HI) || (state == DATA_LO) ||
                (state == DATA_HI) || (state == CSUM);
    if (consuming) begin
      // A byte is never taken in the cycle right after a take, giving the
      // receiver a cycle to drop rx_full.
      rd      = rx_full && !rd_q;
      timeout = !rd && (to_cnt >= TO_LAST);
    end
    case (state)
      IDLE:    if (prog_mode && armed) state_nxt = LEN_LO;
      LEN_LO:  if (rd) state_nxt = LEN_HI;
      LEN_HI:  if (rd) state_nxt = ({rx_data, len_lo} == 16'd0) ? CSUM : DATA_LO;
      DATA_LO: if (rd) state_nxt = DATA_HI;
      DATA_HI: if (rd) state_nxt = last_word ? CSUM : DATA_LO;
      CSUM:    if (rd) state_nxt = SEND;
      SEND: begin
        if (tx_ready) begin
          wr        = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = SEND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= 1'b0;
      armed     <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tx_data   <= '0;
      cpu_rst   <= 1'b0;
      sum       <= '0;
      len_lo    <= '0;
      len       <= '0;
      data_lo   <= '0;
      word_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      rd_q   <= rd;
      mem_we <= 1'b0;

      if (consuming) to_cnt <= rd ? '0 : to_cnt + TO_W'(1);

      if (rd) begin
        case (state)
          LEN_LO: begin
            len_lo <= rx_data;
            sum    <= sum + rx_data;
          end
          LEN_HI: begin
            len <= {rx_data, len_lo};
            sum <= sum + rx_data;
          end
          DATA_LO: begin
            data_lo <= rx_data;
            sum     <= sum + rx_data;
          end
          DATA_HI: begin
            sum      <= sum + rx_data;
            word_cnt <= word_cnt + 17'd1;
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= ADDR_WIDTH'(word_cnt);
              mem_wdata <= {rx_data, data_lo};
            end
          end
          CSUM:    tx_data <= (rx_data == sum) ? ACK : NAK;
          default: ;
        endcase
      end

      if (timeout) tx_data <= NAK;

      case (state)
        IDLE: begin
          // Re-arm only once prog_mode has been seen low back in IDLE.
          if (!prog_mode) armed <= 1'b1;
          if (state_nxt == LEN_LO) begin
            armed    <= 1'b0;
            cpu_rst  <= 1'b1;
            sum      <= '0;
            word_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        FIN:     cpu_rst <= (tx_data != ACK);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of complete load transactions plus
// hand-written timeout, back-pressure and mid-load reset sequences.
module tb_prog_loader;

  localparam int AW = 2;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          prog_mode = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_full = 1'b0;
  logic          tx_ready = 1'b1;
  logic          rd, wr, mem_we, cpu_rst, prog_done;
  logic [7:0]    tx_data;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .ACK(8'h06), .NAK(8'h15)) dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode), .rx_data(rx_data), .rx_full(rx_full),
    .rd(rd), .tx_data(tx_data), .tx_ready(tx_ready), .wr(wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_rst(cpu_rst), .prog_done(prog_done)
  );

  typedef struct packed {
    logic [127:0] b;     // bytes, first byte in the top 8 bits
    logic [7:0]   n;     // byte count
    logic [3:0]   nw;    // expected mem_we count
    logic [63:0]  wd;    // expected write data, word k at [16k +: 16]
    logic [7:0]   tx;    // expected result byte
    logic         crst;  // expected cpu_rst after FIN
    logic         drop;  // drop prog_mode after the first byte
  } vec_t;

  vec_t vecs [5];

  int n_tests = 0;
  int n_fail  = 0;

  int            mw_cnt = 0, wr_cnt = 0, pd_cnt = 0, b2b = 0;
  logic          rd_last = 1'b0;
  logic [15:0]   wd_cap [0:255];
  logic [AW-1:0] wa_cap [0:255];
  logic [7:0]    tx_cap = 8'h00;

  always @(negedge clk) begin
    if (mem_we) begin
      wd_cap[mw_cnt % 256] = mem_wdata;
      wa_cap[mw_cnt % 256] = mem_addr;
      mw_cnt++;
    end
    if (wr) begin
      tx_cap = tx_data;
      wr_cnt++;
    end
    if (prog_done) pd_cnt++;
    if (rd && rd_last) b2b++;
    rd_last = rd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd"},        32'(rd),        32'd0);
    check({tag, "_wr"},        32'(wr),        32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_prog_done"}, 32'(prog_done), 32'd0);
    check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data = b;
    rx_full = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rd) got = 1'b1;
    end
    @(posedge clk);
    #1;
    rx_full = 1'b0;
    if (!got) expire("rd_wait");
  endtask

  task automatic wait_pd(input int base, input int max_cyc);
    bit seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(posedge clk);
      if (pd_cnt > base) seen = 1'b1;
    end
    if (!seen) expire("prog_done_wait");
    @(negedge clk);
  endtask

  task automatic start_load(output int mw0, output int wr0, output int pd0);
    prog_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    prog_mode = 1'b1;
    mw0 = mw_cnt;
    wr0 = wr_cnt;
    pd0 = pd_cnt;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int mw0, wr0, pd0;
    start_load(mw0, wr0, pd0);
    for (int i = 0; i < int'(v.n); i++) begin
      send_byte(v.b[127-8*i -: 8]);
      if (i == 0) begin
        @(negedge clk);
        check($sformatf("v%0d_cpu_rst_busy", idx), 32'(cpu_rst), 32'd1);
        if (v.drop) prog_mode = 1'b0;
      end
    end
    wait_pd(pd0, 100);
    check($sformatf("v%0d_we_count", idx), 32'(mw_cnt - mw0), 32'(v.nw));
    for (int k = 0; k < int'(v.nw); k++) begin
      check($sformatf("v%0d_addr%0d", idx, k), 32'(wa_cap[(mw0 + k) % 256]), 32'(k));
      check($sformatf("v%0d_data%0d", idx, k), 32'(wd_cap[(mw0 + k) % 256]), 32'(v.wd[16*k +: 16]));
    end
    check($sformatf("v%0d_wr_count", idx), 32'(wr_cnt - wr0), 32'd1);
    check($sformatf("v%0d_tx", idx),       32'(tx_cap),        32'(v.tx));
    check($sformatf("v%0d_cpu_rst", idx),  32'(cpu_rst),       32'(v.crst));
    repeat (5) @(negedge clk);
    check($sformatf("v%0d_cpu_rst_hold", idx), 32'(cpu_rst),       32'(v.crst));
    check($sformatf("v%0d_done_count", idx),   32'(pd_cnt - pd0),  32'd1);
    prog_mode = 1'b0;
  endtask

  initial begin
    int mw0, wr0, pd0;

    vecs[0] = '{b: {56'h02003412CDABC0, 72'd0}, n: 8'd7, nw: 4'd2,
                wd: {32'd0, 16'hABCD, 16'h1234}, tx: 8'h06, crst: 1'b0, drop: 1'b0};
    vecs[1] = '{b: {56'h02003412CDABC1, 72'd0}, n: 8'd7, nw: 4'd2,
                wd: {32'd0, 16'hABCD, 16'h1234}, tx: 8'h15, crst: 1'b1, drop: 1'b0};
    vecs[2] = '{b: {24'h000000, 104'd0}, n: 8'd3, nw: 4'd0,
                wd: 64'd0, tx: 8'h06, crst: 1'b0, drop: 1'b0};
    vecs[3] = '{b: {104'h05001100220033004400550004, 24'd0}, n: 8'd13, nw: 4'd4,
                wd: {16'h0044, 16'h0033, 16'h0022, 16'h0011}, tx: 8'h06, crst: 1'b0, drop: 1'b0};
    vecs[4] = '{b: {40'h010001FF01, 88'd0}, n: 8'd5, nw: 4'd1,
                wd: {48'd0, 16'hFF01}, tx: 8'h06, crst: 1'b0, drop: 1'b1};

    #2 rst = 1'b1;
    #10 check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Inter-byte timeout: length 1 announced, only one data byte arrives.
    start_load(mw0, wr0, pd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h34);
    repeat (TO / 2) @(posedge clk);
    check("to_early_done", 32'(pd_cnt - pd0), 32'd0);
    wait_pd(pd0, 2 * TO);
    check("to_we_count", 32'(mw_cnt - mw0), 32'd0);
    check("to_wr_count", 32'(wr_cnt - wr0), 32'd1);
    check("to_tx",       32'(tx_cap),       32'h15);
    check("to_cpu_rst",  32'(cpu_rst),      32'd1);
    prog_mode = 1'b0;

    // SEND must wait for tx_ready with the result held.
    tx_ready = 1'b0;
    start_load(mw0, wr0, pd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    check("bp_wr_count",   32'(wr_cnt - wr0), 32'd0);
    check("bp_done_count", 32'(pd_cnt - pd0), 32'd0);
    check("bp_tx_held",    32'(tx_data),      32'h06);
    tx_ready = 1'b1;
    wait_pd(pd0, 20);
    check("bp_wr_after", 32'(wr_cnt - wr0), 32'd1);
    check("bp_tx",       32'(tx_cap),       32'h06);
    prog_mode = 1'b0;

    // Reset mid-load after three data bytes.
    start_load(mw0, wr0, pd0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    @(negedge clk);
    #2 rst = 1'b1;
    mw0 = mw_cnt;
    wr0 = wr_cnt;
    pd0 = pd_cnt;
    #1 check_reset("mid");
    @(negedge clk);
    rst = 1'b0;
    prog_mode = 1'b0;
    repeat (20) @(posedge clk);
    check("mid_we_after",   32'(mw_cnt - mw0), 32'd0);
    check("mid_wr_after",   32'(wr_cnt - wr0), 32'd0);
    check("mid_done_after", 32'(pd_cnt - pd0), 32'd0);
    run_vec(vecs[0], 5);

    check("rd_back_to_back", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
